lht_access_ctrl: RTL and testbench
==================================

Name: lht_access_ctrl

Overview:
- Owns the single port of the local history table (LHT) SRAM.
- Shares it between two requesters: the front-end prediction read stream and the branch-resolution history-update stream.
- Sequences the post-reset / context-flush clear walk.
- Buffers updates in a small queue. Prediction reads have priority, with a starvation limit so updates always drain.

Parameters:
- UQ_DEPTH, 4, update queue entries (power of 2, >=2).
- STARVE_LIMIT, 8, max consecutive cycles a non-empty queue may wait before reads are blocked.
- LH_WIDTH, 8, local history bits per LHT entry.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- clear_req  in  1  restart clear walk (ASID/context flush)
- pred_valid  in  1  prediction read request
- pred_PC  in  32  fetch PC
- pred_ASID  in  ASID_WIDTH  address space ID
- pred_ready  out  1  read accepted this cycle when pred_valid
- upd_valid  in  1  history update request
- upd_PC  in  32  branch PC
- upd_ASID  in  ASID_WIDTH  address space ID
- upd_hist  in  LH_WIDTH  full new history value (requester has already shifted)
- upd_ready  out  1  update accepted when upd_valid
- arr_en  out  1  SRAM port enable
- arr_we  out  1  SRAM write enable
- arr_index  out  LHT_INDEX_WIDTH  SRAM row
- arr_wdata  out  LH_WIDTH  SRAM write data
- init_busy  out  1  clear walk in progress

Behaviour:
- Clock and reset:
  - One clock, CLK.
  - RST is synchronous and active-high.
- While RST=1:
  - state<=INIT, init_cnt<=0, queue emptied, starve_cnt<=0.
  - Outputs: arr_en=0, arr_we=0, pred_ready=0, upd_ready=0, init_busy=1.
- Index hashing:
  - index = PC[LHT_INDEX_WIDTH+LHT_ENTRIES_PER_BLOCK : LHT_ENTRIES_PER_BLOCK+1] XOR ASID.
  - Computed combinationally for pred at request time and for upd at enqueue.
  - Queue stores {index, hist}, not the PC.
- States: INIT, RUN.
- INIT:
  - Each cycle (RST=0): arr_en=1, arr_we=1, arr_index=init_cnt, arr_wdata=0; init_cnt++.
  - At init_cnt == 2^LHT_INDEX_WIDTH-1, that write completes and state->RUN next cycle.
  - The walk is therefore exactly 2^LHT_INDEX_WIDTH cycles.
  - pred_ready=0, upd_ready=0, init_busy=1.
  - clear_req during INIT: init_cnt<=0 (walk restarts).
- RUN:
  - init_busy=0.
  - force_drain = (count==UQ_DEPTH) || (starve_cnt>=STARVE_LIMIT).
  - pred_ready = !force_drain.
  - upd_ready = (count<UQ_DEPTH).
- RUN per-cycle arbitration, priority order:
  1. pred_valid && pred_ready: arr_en=1, arr_we=0, arr_index=hash(pred_PC, pred_ASID). SRAM read data is returned by the array 1 cycle later, directly to the predictor; this block does not touch it.
  2. else count>0: arr_en=1, arr_we=1, arr_index/arr_wdata = queue head; pop.
  3. else arr_en=0.
- starve_cnt:
  - Resets to 0 on a pop or when count==0.
  - Otherwise increments, saturating at STARVE_LIMIT.
- Queue:
  - FIFO with circular head/tail pointers of log2(UQ_DEPTH) bits, wrapping naturally.
  - count of log2(UQ_DEPTH)+1 bits.
  - Push and pop in the same cycle: count unchanged, FIFO order preserved.
  - Full: upd_ready=0 and a pop is guaranteed that cycle. A push is not accepted in the same cycle the queue is full, even though a pop occurs.
- Hazard: no forwarding. A read to an index with a pending queued update returns the stale value. This is architecturally allowed (speculative history).
- clear_req in RUN: next cycle state=INIT, init_cnt=0, queue flushed, starve_cnt=0. Any request handshaked in the clear_req cycle is still performed that cycle.
- Simultaneous RST and clear_req: RST wins (identical result).

Decomposition:
- core_types_pkg supplies the existing constants: LHT_INDEX_WIDTH, LHT_ENTRIES_PER_BLOCK, ASID_WIDTH.
- Add to core_types_pkg:
  - LH_WIDTH
  - typedef lht_upd_entry_t {logic [LHT_INDEX_WIDTH-1:0] index; logic [LH_WIDTH-1:0] hist;}
  - typedef enum lht_ctrl_state_t {LHT_INIT, LHT_RUN}
- Sub-module: instantiate the existing lht_index_hash twice (pred path, upd path).
- Queue is inline. No new sub-module.

Test Plan:
- Reset then RST=0, no requests -> init_busy=1, arr_we=1 with arr_index 0,1,...,255 for LHT_INDEX_WIDTH=8. init_busy=0 on cycle 256. No ready asserted before then.
- RUN, ASID=0, pred_PC = 5<<(LHT_ENTRIES_PER_BLOCK+1), and ASID=3 with the same PC -> arr_we=0 with arr_index=5, then arr_index=6. pred_ready=1 both cycles.
- Push 2 updates (hist 0xA5, 0x3C) while pred_valid=0 -> consecutive writes in FIFO order, arr_wdata=0xA5 then 0x3C. count returns to 0.
- Constant pred_valid=1, one update queued -> pred_ready=1 for 8 cycles. On cycle 9 pred_ready=0 and the queue head is written. pred_ready=1 the next cycle.
- Constant pred_valid=1 and upd_valid=1 -> queue fills to 4, upd_ready=0. pred_ready=0 that cycle, pop occurs, upd_ready=1 next cycle.
- clear_req in RUN with 3 queued updates -> no queued write is issued. init_cnt restarts at 0 and the full 256-cycle walk repeats. clear_req at init_cnt=100 restarts the walk at 0.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared core constants and types for the local history table (LHT) path.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Exports index/ASID widths, LH_WIDTH, queue entry and controller state types.
package core_types_pkg;

    localparam int LHT_INDEX_WIDTH       = 8;
    localparam int LHT_ENTRIES_PER_BLOCK = 2;
    localparam int ASID_WIDTH            = 8;
    localparam int LH_WIDTH              = 8;

    // Queued history update: the hashed row plus the already-shifted history.
    typedef struct packed {
        logic [LHT_INDEX_WIDTH-1:0] index;
        logic [LH_WIDTH-1:0]        hist;
    } lht_upd_entry_t;

    typedef enum logic {
        LHT_INIT = 1'b0,
        LHT_RUN  = 1'b1
    } lht_ctrl_state_t;

endpackage

// File: rtl/lht_index_hash.sv
// Maps a PC and ASID to an LHT row: PC block-index bits XOR ASID.
// Latency: purely combinational. Backpressure: none.
// Ports: pc (32b fetch/branch PC), asid (ASID_WIDTH), index (LHT_INDEX_WIDTH row).
module lht_index_hash
    import core_types_pkg::*;
(
    input  logic [31:0]                pc,
    input  logic [ASID_WIDTH-1:0]      asid,
    output logic [LHT_INDEX_WIDTH-1:0] index
);

    // Drop the in-block offset bits so the low index bits come from the block number.
    logic [31:0] pc_shift;
    logic        unused_pc_bits;

    assign pc_shift       = pc >> (LHT_ENTRIES_PER_BLOCK + 1);
    assign index          = pc_shift[LHT_INDEX_WIDTH-1:0] ^ LHT_INDEX_WIDTH'(asid);
    assign unused_pc_bits = ^{pc_shift[31:LHT_INDEX_WIDTH], pc[LHT_ENTRIES_PER_BLOCK:0]};

endmodule

// File: rtl/lht_access_ctrl.sv
// Single-port LHT SRAM arbiter: prediction reads, queued history writes, and a clear walk after reset/flush.
// Latency: SRAM command is issued in the same cycle as the accepted request; queued updates drain when the port is free.
// Backpressure: pred_ready drops when the update queue is full or starved; upd_ready drops when the queue is full.
// Ports: CLK/RST, clear_req, pred_* read request, upd_* update request, arr_* SRAM port, init_busy.
module lht_access_ctrl
    import core_types_pkg::*;
#(
    parameter int UQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int LH_WIDTH     = core_types_pkg::LH_WIDTH
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       clear_req,
    input  logic                       pred_valid,
    input  logic [31:0]                pred_PC,
    input  logic [ASID_WIDTH-1:0]      pred_ASID,
    output logic                       pred_ready,
    input  logic                       upd_valid,
    input  logic [31:0]                upd_PC,
    input  logic [ASID_WIDTH-1:0]      upd_ASID,
    input  logic [LH_WIDTH-1:0]        upd_hist,
    output logic                       upd_ready,
    output logic                       arr_en,
    output logic                       arr_we,
    output logic [LHT_INDEX_WIDTH-1:0] arr_index,
    output logic [LH_WIDTH-1:0]        arr_wdata,
    output logic                       init_busy
);

    localparam int PW = $clog2(UQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    lht_ctrl_state_t            state;
    logic [LHT_INDEX_WIDTH-1:0] init_cnt;
    lht_upd_entry_t             uq [UQ_DEPTH];
    logic [PW-1:0]              head;
    logic [PW-1:0]              tail;
    logic [CW-1:0]              count;
    logic [SW-1:0]              starve_cnt;

    logic [LHT_INDEX_WIDTH-1:0] pred_index;
    logic [LHT_INDEX_WIDTH-1:0] upd_index;
    logic                       run;
    logic                       full;
    logic                       force_drain;
    logic                       rd_go;
    logic                       pop;
    logic                       push;

    lht_index_hash u_pred_hash (
        .pc    (pred_PC),
        .asid  (pred_ASID),
        .index (pred_index)
    );

    lht_index_hash u_upd_hash (
        .pc    (upd_PC),
        .asid  (upd_ASID),
        .index (upd_index)
    );

    assign run         = (state == LHT_RUN) && !RST;
    assign full        = (count == CW'(UQ_DEPTH));
    assign force_drain = full || (starve_cnt >= SW'(STARVE_LIMIT));
    assign pred_ready  = run && !force_drain;
    assign upd_ready   = run && !full;
    assign rd_go       = pred_valid && pred_ready;
    // The flush discards the queue, so draining into the array on that cycle is pointless.
    assign pop         = run && !rd_go && (count != '0) && !clear_req;
    assign push        = upd_valid && upd_ready;
    assign init_busy   = RST || (state == LHT_INIT);

    always_comb begin
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        arr_index = '0;
        arr_wdata = '0;
        if (!RST) begin
            if (state == LHT_INIT) begin
                arr_en    = 1'b1;
                arr_we    = 1'b1;
                arr_index = init_cnt;
            end else if (rd_go) begin
                arr_en    = 1'b1;
                arr_index = pred_index;
            end else if (pop) begin
                arr_en    = 1'b1;
                arr_we    = 1'b1;
                arr_index = uq[head].index;
                arr_wdata = uq[head].hist;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= LHT_INIT;
            init_cnt   <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else if (state == LHT_INIT) begin
            if (clear_req) begin
                init_cnt <= '0;
            end else begin
                // Counter wraps to 0 on the last row, ready for the next flush.
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == '1) begin
                    state <= LHT_RUN;
                end
            end
        end else if (clear_req) begin
            state      <= LHT_INIT;
            init_cnt   <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) begin
                uq[tail] <= '{index: upd_index, hist: upd_hist};
                tail     <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
            if (pop || (count == '0)) begin
                starve_cnt <= '0;
            end else if (starve_cnt < SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lht_access_ctrl.sv
// Bench for lht_access_ctrl: directed scenarios then random traffic against a queue-based reference model.
// Latency: n/a. Backpressure: n/a.
module tb_lht_access_ctrl;
    import core_types_pkg::*;

    localparam int UQ  = 4;
    localparam int SL  = 8;
    localparam int NE  = 1 << LHT_INDEX_WIDTH;
    localparam int BLK = 1 << (LHT_ENTRIES_PER_BLOCK + 1);

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                       RST, clear_req, pred_valid, upd_valid;
    logic [31:0]                pred_PC, upd_PC;
    logic [ASID_WIDTH-1:0]      pred_ASID, upd_ASID;
    logic [LH_WIDTH-1:0]        upd_hist;
    logic                       pred_ready, upd_ready, arr_en, arr_we, init_busy;
    logic [LHT_INDEX_WIDTH-1:0] arr_index;
    logic [LH_WIDTH-1:0]        arr_wdata;

    lht_access_ctrl #(.UQ_DEPTH(UQ), .STARVE_LIMIT(SL), .LH_WIDTH(LH_WIDTH)) dut (
        .CLK(CLK), .RST(RST), .clear_req(clear_req),
        .pred_valid(pred_valid), .pred_PC(pred_PC), .pred_ASID(pred_ASID), .pred_ready(pred_ready),
        .upd_valid(upd_valid), .upd_PC(upd_PC), .upd_ASID(upd_ASID), .upd_hist(upd_hist),
        .upd_ready(upd_ready), .arr_en(arr_en), .arr_we(arr_we), .arr_index(arr_index),
        .arr_wdata(arr_wdata), .init_busy(init_busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: clearing flag + row counter, update queue, wait counter.
    bit m_init = 1'b1;
    int m_wcnt = 0;
    int m_qi[$];
    int m_qh[$];
    int m_wait = 0;

    int last_idx, last_wd;
    bit last_en, last_we, last_pr, last_ur, last_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int hashm(input logic [31:0] pc, input logic [ASID_WIDTH-1:0] a);
        return ((pc / BLK) % NE) ^ int'(a);
    endfunction

    task automatic cyc();
        bit e_en, e_we, e_pr, e_ur, e_busy, popped;
        int e_idx, e_wd, sz;
        @(negedge CLK);
        e_en = 0; e_we = 0; e_pr = 0; e_ur = 0; e_busy = 0; popped = 0;
        e_idx = 0; e_wd = 0;
        if (RST) begin
            e_busy = 1;
        end else if (m_init) begin
            e_en = 1; e_we = 1; e_idx = m_wcnt; e_busy = 1;
        end else begin
            e_ur = (m_qi.size() < UQ);
            e_pr = e_ur && (m_wait < SL);
            if (pred_valid && e_pr) begin
                e_en = 1; e_idx = hashm(pred_PC, pred_ASID);
            end else if (m_qi.size() > 0 && !clear_req) begin
                popped = 1; e_en = 1; e_we = 1; e_idx = m_qi[0]; e_wd = m_qh[0];
            end
        end
        last_idx = int'(arr_index); last_wd = int'(arr_wdata); last_en = arr_en; last_we = arr_we;
        last_pr = pred_ready; last_ur = upd_ready; last_busy = init_busy;
        check("arr_en", 32'(arr_en), 32'(e_en));
        check("arr_we", 32'(arr_we), 32'(e_we));
        if (e_en) check("arr_index", 32'(arr_index), e_idx);
        if (e_we) check("arr_wdata", 32'(arr_wdata), e_wd);
        check("pred_ready", 32'(pred_ready), 32'(e_pr));
        check("upd_ready", 32'(upd_ready), 32'(e_ur));
        check("init_busy", 32'(init_busy), 32'(e_busy));
        @(posedge CLK);
        if (RST || (!m_init && clear_req)) begin
            m_init = 1; m_wcnt = 0; m_qi.delete(); m_qh.delete(); m_wait = 0;
        end else if (m_init) begin
            if (clear_req) m_wcnt = 0;
            else if (m_wcnt == NE - 1) begin m_init = 0; m_wcnt = 0; end
            else m_wcnt++;
        end else begin
            sz = m_qi.size();
            if (popped) begin
                void'(m_qi.pop_front());
                void'(m_qh.pop_front());
            end
            m_wait = (popped || sz == 0) ? 0 : ((m_wait < SL) ? m_wait + 1 : SL);
            if (upd_valid && e_ur) begin
                m_qi.push_back(hashm(upd_PC, upd_ASID));
                m_qh.push_back(int'(upd_hist));
            end
        end
        #1;
    endtask

    initial begin
        RST = 1; clear_req = 0; pred_valid = 0; upd_valid = 0;
        pred_PC = 0; upd_PC = 0; pred_ASID = 0; upd_ASID = 0; upd_hist = 0;

        repeat (3) cyc();
        check("rst_arr_en", 32'(last_en), 0);
        check("rst_busy", 32'(last_busy), 1);

        // Full clear walk with no requests.
        RST = 0;
        cyc();
        check("walk_first_idx", last_idx, 0);
        repeat (NE - 1) cyc();
        check("walk_last_idx", last_idx, NE - 1);
        check("walk_last_busy", 32'(last_busy), 1);

        // Prediction read hashing.
        pred_valid = 1; pred_PC = 32'(5 * BLK); pred_ASID = 0;
        cyc();
        check("run_busy", 32'(last_busy), 0);
        check("hash_asid0", last_idx, 5);
        check("hash_pr0", 32'(last_pr), 1);
        pred_ASID = 3;
        cyc();
        check("hash_asid3", last_idx, 6);
        check("hash_pr3", 32'(last_pr), 1);
        pred_valid = 0;

        // Two updates drain in FIFO order while reads are idle.
        upd_valid = 1; upd_PC = 32'h0000_0040; upd_ASID = 8'h11; upd_hist = 8'hA5;
        cyc();
        upd_PC = 32'h0000_0120; upd_hist = 8'h3C;
        cyc();
        check("fifo_wd0", last_wd, 32'hA5);
        upd_valid = 0;
        cyc();
        check("fifo_wd1", last_wd, 32'h3C);
        cyc();
        check("fifo_empty_en", 32'(last_en), 0);

        // Starvation limit: reads win for SL cycles, then the queue head is forced out.
        pred_valid = 1; pred_PC = 32'h0000_1000;
        upd_valid = 1; upd_hist = 8'h5A;
        cyc();
        upd_valid = 0;
        for (int i = 0; i < SL; i++) begin
            cyc();
            check("starve_pr_hi", 32'(last_pr), 1);
        end
        cyc();
        check("starve_pr_lo", 32'(last_pr), 0);
        check("starve_wd", last_wd, 32'h5A);
        cyc();
        check("starve_pr_back", 32'(last_pr), 1);

        // Constant reads and updates fill the queue, forcing a drain.
        upd_valid = 1;
        for (int i = 0; i < UQ; i++) begin
            upd_hist = 8'(8'h10 + i);
            cyc();
        end
        cyc();
        check("full_ur", 32'(last_ur), 0);
        check("full_pr", 32'(last_pr), 0);
        check("full_we", 32'(last_we), 1);
        cyc();
        check("full_ur_back", 32'(last_ur), 1);
        pred_valid = 0; upd_valid = 0;
        repeat (UQ + 2) cyc();

        // Flush with three pending updates; the read on the flush cycle is still issued.
        pred_valid = 1; upd_valid = 1;
        for (int i = 0; i < 3; i++) begin
            upd_hist = 8'(8'hE0 + i);
            cyc();
        end
        upd_valid = 0; clear_req = 1;
        cyc();
        check("clr_read_we", 32'(last_we), 0);
        clear_req = 0; pred_valid = 0;
        repeat (101) cyc();
        check("clr_idx100", last_idx, 100);
        clear_req = 1;
        cyc();
        clear_req = 0;
        cyc();
        check("clr_restart_idx", last_idx, 0);
        repeat (NE - 1) cyc();
        check("clr_walk_end", last_idx, NE - 1);
        cyc();
        check("clr_run_busy", 32'(last_busy), 0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            RST        = ($urandom_range(0, 299) == 0);
            clear_req  = ($urandom_range(0, 199) == 0);
            pred_valid = ($urandom_range(0, 99) < 60);
            upd_valid  = ($urandom_range(0, 99) < 45);
            pred_PC    = $urandom;
            upd_PC     = $urandom;
            pred_ASID  = ASID_WIDTH'($urandom);
            upd_ASID   = ASID_WIDTH'($urandom);
            upd_hist   = LH_WIDTH'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
